lsu_ctrl: RTL and testbench

//  Load/store initiator between the CPU datapath and the word-only data memory (dm).

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/lsu_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller.
// Access sizes, FSM state encoding and the default address limit.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane steering for the load/store controller.
// merge_i=0: extract+extend a load; merge_i=1: merge store data into a word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        merge_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed lane, then either extend it or replace it
    always_comb begin
        byte_v   = word_i[{lane_i, 3'b000} +: 8];
        half_v   = lane_i[1] ? word_i[31:16] : word_i[15:0];
        result_o = '0;
        if (merge_i) begin
            result_o = word_i;
            case (size_i)
                SIZE_BYTE: result_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
                SIZE_HALF: begin
                    if (lane_i[1]) result_o[31:16] = wdata_i[15:0];
                    else           result_o[15:0]  = wdata_i[15:0];
                end
                SIZE_WORD: result_o = wdata_i;
                default:   result_o = word_i;
            endcase
        end else begin
            case (size_i)
                SIZE_BYTE: result_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
                SIZE_HALF: result_o = {{16{~unsigned_i & half_v[15]}}, half_v};
                SIZE_WORD: result_o = word_i;
                default:   result_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator for the word-only data memory; sub-word stores use RMW.
// Define LSU_ALIGN_CHECK_EN to fault misaligned half/word accesses.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merged_q, merged_d;

    logic        misalign;
    logic        req_err;
    logic        mem_we_raw;
    logic [31:0] word_addr;
    logic [31:0] load_res;
    logic [31:0] store_res;

    assign word_addr = {addr_q[31:2], 2'b00};
    assign mem_we    = mem_we_raw && !reset;

    // Classify the incoming request as faulting before it is accepted
    always_comb begin
        misalign = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        misalign = ((req_size == SIZE_HALF) && req_addr[0]) ||
                   ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`endif
        req_err = (req_addr >= ADDR_LIMIT) ||
                  (req_size == SIZE_RSVD) || misalign;
    end

    lsu_lane_align u_load (
        .merge_i    (1'b0),
        .word_i     (mem_rdata),
        .wdata_i    (wdata_q),
        .lane_i     (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (load_res)
    );

    lsu_lane_align u_store (
        .merge_i    (1'b1),
        .word_i     (mem_rdata),
        .wdata_i    (wdata_q),
        .lane_i     (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (store_res)
    );

    // State and request-context registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            size_q   <= SIZE_BYTE;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            merged_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            merged_q <= merged_d;
        end
    end

    // Next-state, context capture and memory/response outputs
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        merged_d   = merged_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_we_raw = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    rdata_d = '0;
                    state_d = req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_addr = word_addr;
                if (!we_q) begin
                    rdata_d = load_res;
                    state_d = ST_RESP;
                end else if (size_q == SIZE_WORD) begin
                    mem_we_raw = 1'b1;
                    mem_wdata  = wdata_q;
                    state_d    = ST_RESP;
                end else begin
                    merged_d = store_res;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_addr   = word_addr;
                mem_we_raw = 1'b1;
                mem_wdata  = merged_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl with a behavioural word memory.
// Honours LSU_ALIGN_CHECK_EN when checking misaligned accesses.
module tb_lsu_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:4095];
    int          wr_cnt;
    int          n_cmp;
    int          n_err;

    lsu_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'h4000) ? mem[mem_addr[13:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[13:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // lat counts posedges from the accept edge until resp_valid is seen
    task automatic do_req(input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat,
                          output logic [31:0] rd, output logic er);
        @(negedge clk);
        check("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk);
        #1;
        check("resp_pulse", {31'b0, resp_valid}, 32'd0);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          w0;

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        wr_cnt       = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rvalid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'b0, resp_err}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;

        // word store then load
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
        check("sw_lat", lat, 32'd2);
        check("sw_err", {31'b0, er}, 32'd0);
        check("sw_rdata", rd, 32'd0);
        check("sw_mem", mem[4], 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er);
        check("lw_lat", lat, 32'd2);
        check("lw_data", rd, 32'hDEADBEEF);
        check("lw_err", {31'b0, er}, 32'd0);

        // byte loads of other lanes
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat, rd, er);
        check("lb_lane3", rd, 32'hFFFFFFDE);
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, lat, rd, er);
        check("lbu_lane1", rd, 32'h000000BE);

        // byte RMW
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, lat, rd, er);
        w0 = wr_cnt;
        do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, lat, rd, er);
        check("sb_lat", lat, 32'd3);
        check("sb_writes", wr_cnt - w0, 32'd1);
        check("sb_mem", mem[8], 32'h11AA3344);
        do_req(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, lat, rd, er);
        check("lb_data", rd, 32'hFFFFFFAA);
        do_req(1'b0, 2'd0, 1'b1, 32'h22, 32'h0, lat, rd, er);
        check("lbu_data", rd, 32'h000000AA);

        // half RMW on upper lane
        do_req(1'b1, 2'd2, 1'b0, 32'h24, 32'h55667788, lat, rd, er);
        do_req(1'b1, 2'd1, 1'b0, 32'h26, 32'h00008001, lat, rd, er);
        check("sh_lat", lat, 32'd3);
        check("sh_mem", mem[9], 32'h80017788);
        do_req(1'b0, 2'd1, 1'b0, 32'h26, 32'h0, lat, rd, er);
        check("lh_data", rd, 32'hFFFF8001);
        do_req(1'b0, 2'd1, 1'b1, 32'h26, 32'h0, lat, rd, er);
        check("lhu_data", rd, 32'h00008001);
        do_req(1'b0, 2'd1, 1'b0, 32'h24, 32'h0, lat, rd, er);
        check("lh_low", rd, 32'h00007788);

        // limit and reserved-size errors
        w0 = wr_cnt;
        do_req(1'b1, 2'd2, 1'b0, 32'h3000, 32'hCAFEF00D, lat, rd, er);
        check("lim_lat", lat, 32'd1);
        check("lim_err", {31'b0, er}, 32'd1);
        check("lim_rdata", rd, 32'd0);
        check("lim_nowrite", wr_cnt - w0, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0, lat, rd, er);
        check("below_lim_err", {31'b0, er}, 32'd0);
        do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678, lat, rd, er);
        check("rsvd_lat", lat, 32'd1);
        check("rsvd_err", {31'b0, er}, 32'd1);
        check("rsvd_nowrite", wr_cnt - w0, 32'd0);
        check("rsvd_mem", mem[4], 32'hDEADBEEF);

        // misaligned word load
        do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, lat, rd, er);
`ifdef LSU_ALIGN_CHECK_EN
        check("mis_err", {31'b0, er}, 32'd1);
        check("mis_rdata", rd, 32'd0);
        check("mis_lat", lat, 32'd1);
`else
        check("mis_err", {31'b0, er}, 32'd0);
        check("mis_rdata", rd, 32'hDEADBEEF);
        check("mis_lat", lat, 32'd2);
`endif

        // reset during WRITE of a byte store
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h20;
        req_wdata    = 32'h00000055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wr_state_we", {31'b0, mem_we}, 32'd1);
        w0    = wr_cnt;
        reset = 1'b1;
        #1;
        check("rst_blocks_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_nowrite", wr_cnt - w0, 32'd0);
        check("rst_mem", mem[8], 32'h11AA3344);
        check("rst_idle_ready", {31'b0, req_ready}, 32'd1);
        check("rst_idle_rvalid", {31'b0, resp_valid}, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, rd, er);
        check("post_rst_lw", rd, 32'h11AA3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
